// File: rtl/imager_frame_scheduler_if.sv
// Frame handshake bundle between the frame scheduler (master), the exposure
// sequencer (FSMIND0/FSMIND1 pair) and the ADC readout FSM (RO_START/RO_DONE).
interface imager_frame_scheduler_if;
  logic FSMIND1;
  logic FSMIND1ACK;
  logic FSMIND0;
  logic FSMIND0ACK;
  logic RO_START;
  logic RO_DONE;

  modport master (
    input  FSMIND1, FSMIND0ACK, RO_DONE,
    output FSMIND1ACK, FSMIND0, RO_START
  );

  modport slave (
    output FSMIND1, FSMIND0ACK, RO_DONE,
    input  FSMIND1ACK, FSMIND0, RO_START
  );
endinterface

// File: rtl/imager_frame_scheduler.sv
// Frame-level scheduler: gates exposure frames, triggers readout and holds the
// active exposure configuration stable. Optional watchdog: SCHED_WATCHDOG_EN.
module imager_frame_scheduler #(
  parameter logic [31:0] C_TIMEOUT  = 32'd100000000,
  parameter logic [31:0] C_EXP_DEF  = 32'd10,
  parameter logic [31:0] C_NPAT_DEF = 32'd100,
  parameter logic [31:0] C_NMC_DEF  = 32'd0,
  parameter logic [31:0] C_MCS_DEF  = 32'd1
) (
  input  logic                      CLK_HS,
  input  logic                      RESET,
  input  logic                      START,
  input  logic                      STOP,
  input  logic                      MODE,
  input  logic [31:0]               NUM_FRAMES,
  input  logic                      CFG_WE,
  input  logic [31:0]               CFG_EXP,
  input  logic [31:0]               CFG_NPAT,
  input  logic [31:0]               CFG_NMC,
  input  logic [31:0]               CFG_MCS,
  output logic [31:0]               Exp_subc,
  output logic [31:0]               Num_Pat,
  output logic [31:0]               Num_Mask_change,
  output logic [31:0]               Mask_change_subc,
  imager_frame_scheduler_if.master  hs,
  output logic                      BUSY,
  output logic [31:0]               FRAME_CNT,
  output logic                      TIMEOUT_ERR,
  output logic [2:0]                sched_stat
);

  localparam logic [2:0] ST_FLUSH   = 3'd0;
  localparam logic [2:0] ST_IDLE    = 3'd1;
  localparam logic [2:0] ST_RELEASE = 3'd2;
  localparam logic [2:0] ST_EXPOSE  = 3'd3;
  localparam logic [2:0] ST_READOUT = 3'd4;
  localparam logic [2:0] ST_ERROR   = 3'd7;

  // A zero exposure or zero subscene count would stall the sequencer.
  function automatic logic [31:0] nonzero(input logic [31:0] v);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

  logic [2:0]  state_r;
  logic [2:0]  state_fsm_s;
  logic [2:0]  state_next_s;
  logic        start_ok_s;
  logic [31:0] frame_inc_s;
  logic        wd_hit_s;
  logic        mode_r;
  logic [31:0] num_frames_r;
  logic        stop_pend_r;
  logic [31:0] exp_sh_r;
  logic [31:0] npat_sh_r;
  logic [31:0] nmc_sh_r;
  logic [31:0] mcs_sh_r;

  assign sched_stat = state_r;

  // Next-state decode of the frame handshake sequence.
  always_comb begin
    state_fsm_s = state_r;
    start_ok_s  = 1'b0;
    frame_inc_s = FRAME_CNT + 32'd1;
    case (state_r)
      ST_FLUSH: begin
        if (hs.FSMIND1) state_fsm_s = ST_IDLE;
        else            state_fsm_s = ST_FLUSH;
      end
      ST_IDLE: begin
        if (START && !STOP && (MODE || (NUM_FRAMES != 32'd0))) begin
          state_fsm_s = ST_RELEASE;
          start_ok_s  = 1'b1;
        end else begin
          state_fsm_s = ST_IDLE;
        end
      end
      ST_RELEASE: begin
        if (hs.FSMIND0ACK) state_fsm_s = ST_EXPOSE;
        else               state_fsm_s = ST_RELEASE;
      end
      ST_EXPOSE: begin
        if (hs.FSMIND1) state_fsm_s = ST_READOUT;
        else            state_fsm_s = ST_EXPOSE;
      end
      ST_READOUT: begin
        if (hs.RO_DONE) begin
          if (stop_pend_r || STOP || (!mode_r && (frame_inc_s == num_frames_r)))
            state_fsm_s = ST_IDLE;
          else
            state_fsm_s = ST_RELEASE;
        end else begin
          state_fsm_s = ST_READOUT;
        end
      end
      ST_ERROR: state_fsm_s = ST_ERROR;
      default:  state_fsm_s = ST_FLUSH;
    endcase
  end

  assign state_next_s = wd_hit_s ? ST_ERROR : state_fsm_s;

  // State, handshake outputs, frame counter and active configuration.
  always_ff @(posedge CLK_HS) begin
    if (RESET) begin
      state_r          <= ST_FLUSH;
      BUSY             <= 1'b1;
      hs.FSMIND0       <= 1'b0;
      hs.FSMIND1ACK    <= 1'b0;
      hs.RO_START      <= 1'b0;
      FRAME_CNT        <= 32'd0;
      mode_r           <= 1'b0;
      num_frames_r     <= 32'd0;
      stop_pend_r      <= 1'b0;
      Exp_subc         <= C_EXP_DEF;
      Num_Pat          <= C_NPAT_DEF;
      Num_Mask_change  <= C_NMC_DEF;
      Mask_change_subc <= C_MCS_DEF;
    end else begin
      state_r       <= state_next_s;
      BUSY          <= (state_next_s != ST_IDLE);
      hs.FSMIND0    <= (state_next_s == ST_RELEASE);
      // The sequencer stays parked while the ack is high, i.e. until it takes FSMIND0.
      hs.FSMIND1ACK <= (state_next_s == ST_IDLE) || (state_next_s == ST_RELEASE) ||
                       (state_next_s == ST_READOUT);
      hs.RO_START   <= (state_r == ST_EXPOSE) && (state_next_s == ST_READOUT);
      if (start_ok_s) begin
        FRAME_CNT    <= 32'd0;
        mode_r       <= MODE;
        num_frames_r <= NUM_FRAMES;
        stop_pend_r  <= 1'b0;
      end else begin
        if ((state_r == ST_READOUT) && hs.RO_DONE && (state_next_s != ST_ERROR))
          FRAME_CNT <= frame_inc_s;
        if (STOP && (state_r != ST_IDLE))
          stop_pend_r <= 1'b1;
      end
      if ((state_next_s == ST_RELEASE) && (state_r != ST_RELEASE)) begin
        Exp_subc         <= exp_sh_r;
        Num_Pat          <= npat_sh_r;
        Num_Mask_change  <= nmc_sh_r;
        Mask_change_subc <= mcs_sh_r;
      end
    end
  end

  // Host-written shadow configuration.
  always_ff @(posedge CLK_HS) begin
    if (RESET) begin
      exp_sh_r  <= C_EXP_DEF;
      npat_sh_r <= C_NPAT_DEF;
      nmc_sh_r  <= C_NMC_DEF;
      mcs_sh_r  <= C_MCS_DEF;
    end else if (CFG_WE) begin
      exp_sh_r  <= nonzero(CFG_EXP);
      npat_sh_r <= CFG_NPAT;
      nmc_sh_r  <= CFG_NMC;
      mcs_sh_r  <= nonzero(CFG_MCS);
    end
  end

`ifdef SCHED_WATCHDOG_EN
  logic [31:0] wd_cnt_r;
  logic        wd_counted_s;

  assign wd_counted_s = (state_r == ST_FLUSH) || (state_r == ST_RELEASE) ||
                        (state_r == ST_EXPOSE) || (state_r == ST_READOUT);
  // Trip on the edge the count would reach the limit: exactly C_TIMEOUT cycles per visit.
  assign wd_hit_s     = wd_counted_s && ((wd_cnt_r + 32'd1) == C_TIMEOUT);

  // Per-visit watchdog counter and sticky error flag.
  always_ff @(posedge CLK_HS) begin
    if (RESET) begin
      wd_cnt_r    <= 32'd0;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      if (state_next_s != state_r)
        wd_cnt_r <= 32'd0;
      else if (wd_counted_s)
        wd_cnt_r <= wd_cnt_r + 32'd1;
      if (state_next_s == ST_ERROR)
        TIMEOUT_ERR <= 1'b1;
    end
  end
`else
  assign wd_hit_s    = 1'b0;
  assign TIMEOUT_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_imager_frame_scheduler.sv
// Scoreboard bench for imager_frame_scheduler with sequencer and readout models.
module tb_imager_frame_scheduler;

  logic        CLK_HS = 1'b0;
  logic        RESET  = 1'b1;
  logic        START, STOP, MODE, CFG_WE;
  logic [31:0] NUM_FRAMES, CFG_EXP, CFG_NPAT, CFG_NMC, CFG_MCS;
  logic [31:0] Exp_subc, Num_Pat, Num_Mask_change, Mask_change_subc, FRAME_CNT;
  logic        BUSY, TIMEOUT_ERR;
  logic [2:0]  sched_stat;

  imager_frame_scheduler_if hs();

  imager_frame_scheduler #(.C_TIMEOUT(32'd1000)) dut (
    .CLK_HS(CLK_HS), .RESET(RESET), .START(START), .STOP(STOP), .MODE(MODE),
    .NUM_FRAMES(NUM_FRAMES), .CFG_WE(CFG_WE), .CFG_EXP(CFG_EXP), .CFG_NPAT(CFG_NPAT),
    .CFG_NMC(CFG_NMC), .CFG_MCS(CFG_MCS), .Exp_subc(Exp_subc), .Num_Pat(Num_Pat),
    .Num_Mask_change(Num_Mask_change), .Mask_change_subc(Mask_change_subc), .hs(hs),
    .BUSY(BUSY), .FRAME_CNT(FRAME_CNT), .TIMEOUT_ERR(TIMEOUT_ERR), .sched_stat(sched_stat)
  );

  always #5 CLK_HS = ~CLK_HS;

  typedef struct {
    logic [31:0] cnt;
    logic [31:0] exp;
    logic [31:0] npat;
    logic [31:0] nmc;
    logic [31:0] mcs;
  } frame_t;

  frame_t exp_q[$];
  int     checks  = 0;
  int     errors  = 0;
  int     hs_cnt  = 0;
  bit     hold_ro = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic push(input logic [31:0] c, input logic [31:0] e, input logic [31:0] p,
                      input logic [31:0] n, input logic [31:0] m);
    frame_t f;
    f.cnt = c; f.exp = e; f.npat = p; f.nmc = n; f.mcs = m;
    exp_q.push_back(f);
  endtask

  task automatic wait_stat(input logic [2:0] s, input int budget, input string name);
    int n = 0;
    do begin
      @(negedge CLK_HS);
      n++;
    end while ((sched_stat != s) && (n < budget));
    check(name, 32'(sched_stat), 32'(s));
  endtask

  task automatic pulse_start();
    START = 1'b1;
    @(negedge CLK_HS);
    START = 1'b0;
  endtask

  // Exposure sequencer model: autonomous flush frame, then FSMIND0-driven frames.
  initial begin
    int n;
    hs.FSMIND1    = 1'b0;
    hs.FSMIND0ACK = 1'b0;
    do @(negedge CLK_HS); while (RESET);
    repeat (50) @(negedge CLK_HS);
    check("flush_ack_before", 32'(hs.FSMIND1ACK), 32'd0);
    hs.FSMIND1 = 1'b1;
    @(negedge CLK_HS);
    check("flush_ack", 32'(hs.FSMIND1ACK), 32'd1);
    check("flush_no_ro_start", 32'(hs.RO_START), 32'd0);
    check("flush_stat", 32'(sched_stat), 32'd1);
    check("flush_busy", 32'(BUSY), 32'd0);
    hs.FSMIND1 = 1'b0;
    forever begin
      @(negedge CLK_HS);
      if (hs.FSMIND0) begin
        hs.FSMIND0ACK = 1'b1;
        hs_cnt++;
        n = 0;
        do begin @(negedge CLK_HS); n++; end while (hs.FSMIND1ACK && (n < 20));
        check("ack_cleared", 32'(hs.FSMIND1ACK), 32'd0);
        check("fsmind0_dropped", 32'(hs.FSMIND0), 32'd0);
        repeat (10) @(negedge CLK_HS);
        hs.FSMIND0ACK = 1'b0;
        hs.FSMIND1    = 1'b1;
        n = 0;
        do begin @(negedge CLK_HS); n++; end while (!hs.FSMIND1ACK && (n < 20));
        check("frame_end_ack", 32'(hs.FSMIND1ACK), 32'd1);
        hs.FSMIND1 = 1'b0;
      end
    end
  end

  // ADC readout model: RO_DONE five cycles after RO_START unless withheld.
  initial begin
    hs.RO_DONE = 1'b0;
    forever begin
      @(negedge CLK_HS);
      if (hs.RO_START && !hold_ro) begin
        repeat (4) @(negedge CLK_HS);
        hs.RO_DONE = 1'b1;
        @(negedge CLK_HS);
        hs.RO_DONE = 1'b0;
      end
    end
  end

  // Scoreboard monitor: every RO_START must match the next expected frame.
  initial begin
    frame_t f;
    forever begin
      @(negedge CLK_HS);
      if (hs.RO_START) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ro_start: got RO_START at frame_cnt %0d, expected none", FRAME_CNT);
        end else begin
          f = exp_q.pop_front();
          check("ro_frame_cnt", FRAME_CNT, f.cnt);
          check("ro_exp_subc", Exp_subc, f.exp);
          check("ro_num_pat", Num_Pat, f.npat);
          check("ro_num_mask_change", Num_Mask_change, f.nmc);
          check("ro_mask_change_subc", Mask_change_subc, f.mcs);
          check("ro_ack_high", 32'(hs.FSMIND1ACK), 32'd1);
        end
        @(negedge CLK_HS);
        check("ro_start_width", 32'(hs.RO_START), 32'd0);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no end of run, expected $finish");
    $fatal(1, "time limit");
  end

  initial begin
    int n;
    START = 1'b0; STOP = 1'b0; MODE = 1'b0; CFG_WE = 1'b0; NUM_FRAMES = 32'd0;
    CFG_EXP = 32'd0; CFG_NPAT = 32'd0; CFG_NMC = 32'd0; CFG_MCS = 32'd0;
    repeat (3) @(negedge CLK_HS);
    check("rst_stat", 32'(sched_stat), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd1);
    check("rst_fsmind0", 32'(hs.FSMIND0), 32'd0);
    check("rst_fsmind1ack", 32'(hs.FSMIND1ACK), 32'd0);
    check("rst_ro_start", 32'(hs.RO_START), 32'd0);
    check("rst_timeout_err", 32'(TIMEOUT_ERR), 32'd0);
    check("rst_frame_cnt", FRAME_CNT, 32'd0);
    check("rst_exp", Exp_subc, 32'd10);
    check("rst_npat", Num_Pat, 32'd100);
    check("rst_nmc", Num_Mask_change, 32'd0);
    check("rst_mcs", Mask_change_subc, 32'd1);
    RESET = 1'b0;
    wait_stat(3'd1, 200, "flush_to_idle");

    // Counted run of three frames.
    push(32'd0, 32'd10, 32'd100, 32'd0, 32'd1);
    push(32'd1, 32'd10, 32'd100, 32'd0, 32'd1);
    push(32'd2, 32'd10, 32'd100, 32'd0, 32'd1);
    MODE = 1'b0; NUM_FRAMES = 32'd3;
    pulse_start();
    check("counted_busy", 32'(BUSY), 32'd1);
    wait_stat(3'd1, 2000, "counted_idle");
    check("counted_frame_cnt", FRAME_CNT, 32'd3);
    check("counted_fsmind0", 32'(hs.FSMIND0), 32'd0);
    repeat (20) @(negedge CLK_HS);
    check("counted_handshakes", 32'(hs_cnt), 32'd3);
    check("counted_sb_empty", 32'(exp_q.size()), 32'd0);

    // Continuous run stopped during the second exposure.
    push(32'd0, 32'd10, 32'd100, 32'd0, 32'd1);
    push(32'd1, 32'd10, 32'd100, 32'd0, 32'd1);
    MODE = 1'b1; NUM_FRAMES = 32'd0;
    pulse_start();
    n = 0;
    do begin @(negedge CLK_HS); n++; end while (!((hs_cnt == 5) && (sched_stat == 3'd3)) && (n < 500));
    check("cont_second_expose", 32'(sched_stat), 32'd3);
    STOP = 1'b1;
    @(negedge CLK_HS);
    STOP = 1'b0;
    wait_stat(3'd1, 500, "cont_idle");
    check("cont_frame_cnt", FRAME_CNT, 32'd2);
    repeat (20) @(negedge CLK_HS);
    check("cont_handshakes", 32'(hs_cnt), 32'd5);
    check("cont_sb_empty", 32'(exp_q.size()), 32'd0);

    // Shadow write mid-exposure takes effect only at the next RELEASE.
    push(32'd0, 32'd10, 32'd100, 32'd0, 32'd1);
    push(32'd1, 32'd25, 32'd200, 32'd3, 32'd1);
    MODE = 1'b0; NUM_FRAMES = 32'd2;
    pulse_start();
    wait_stat(3'd3, 100, "cfg_expose");
    CFG_EXP = 32'd25; CFG_NPAT = 32'd200; CFG_NMC = 32'd3; CFG_MCS = 32'd0; CFG_WE = 1'b1;
    @(negedge CLK_HS);
    CFG_WE = 1'b0;
    check("cfg_exp_held", Exp_subc, 32'd10);
    check("cfg_npat_held", Num_Pat, 32'd100);
    wait_stat(3'd1, 1000, "cfg_idle");
    check("cfg_frame_cnt", FRAME_CNT, 32'd2);
    check("cfg_exp_new", Exp_subc, 32'd25);
    check("cfg_mcs_zero_as_one", Mask_change_subc, 32'd1);

    // Ignored starts: STOP in the same cycle, and a zero-frame counted run.
    MODE = 1'b1; START = 1'b1; STOP = 1'b1;
    @(negedge CLK_HS);
    START = 1'b0; STOP = 1'b0;
    repeat (3) @(negedge CLK_HS);
    check("startstop_stat", 32'(sched_stat), 32'd1);
    check("startstop_busy", 32'(BUSY), 32'd0);
    check("startstop_frame_cnt", FRAME_CNT, 32'd2);
    check("startstop_fsmind0", 32'(hs.FSMIND0), 32'd0);
    MODE = 1'b0; NUM_FRAMES = 32'd0;
    pulse_start();
    repeat (3) @(negedge CLK_HS);
    check("zero_frames_stat", 32'(sched_stat), 32'd1);
    check("zero_frames_frame_cnt", FRAME_CNT, 32'd2);
    check("zero_frames_fsmind0", 32'(hs.FSMIND0), 32'd0);

    // Single-frame run with a zero exposure write.
    CFG_EXP = 32'd0; CFG_NPAT = 32'd5; CFG_NMC = 32'd2; CFG_MCS = 32'd7; CFG_WE = 1'b1;
    @(negedge CLK_HS);
    CFG_WE = 1'b0;
    check("idle_write_exp_held", Exp_subc, 32'd25);
    push(32'd0, 32'd1, 32'd5, 32'd2, 32'd7);
    NUM_FRAMES = 32'd1;
    pulse_start();
    wait_stat(3'd1, 500, "single_idle");
    check("single_frame_cnt", FRAME_CNT, 32'd1);
    check("single_exp_zero_as_one", Exp_subc, 32'd1);
    check("single_sb_empty", 32'(exp_q.size()), 32'd0);

`ifdef SCHED_WATCHDOG_EN
    hold_ro = 1'b1;
    push(32'd0, 32'd1, 32'd5, 32'd2, 32'd7);
    pulse_start();
    wait_stat(3'd4, 200, "wd_readout");
    n = 0;
    do begin @(negedge CLK_HS); n++; end while ((sched_stat != 3'd7) && (n < 1100));
    check("wd_cycles_in_readout", 32'(n), 32'd1000);
    check("wd_timeout_err", 32'(TIMEOUT_ERR), 32'd1);
    check("wd_fsmind0", 32'(hs.FSMIND0), 32'd0);
    check("wd_fsmind1ack", 32'(hs.FSMIND1ACK), 32'd0);
    check("wd_ro_start", 32'(hs.RO_START), 32'd0);
    check("wd_busy", 32'(BUSY), 32'd1);
    pulse_start();
    repeat (5) @(negedge CLK_HS);
    check("wd_sticky_stat", 32'(sched_stat), 32'd7);
    check("wd_sticky_err", 32'(TIMEOUT_ERR), 32'd1);
    RESET = 1'b1;
    @(negedge CLK_HS);
    RESET = 1'b0;
    check("wd_reset_stat", 32'(sched_stat), 32'd0);
    check("wd_reset_err", 32'(TIMEOUT_ERR), 32'd0);
`else
    check("no_wd_timeout_err", 32'(TIMEOUT_ERR), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imager_frame_scheduler.md
# imager_frame_scheduler

Frame-level scheduler for the coded-exposure imager. It owns the FSMIND0/FSMIND1 handshake with the exposure sequencer and the start/done handshake with the ADC readout FSM. It decides when the exposure sequencer may start the next frame, and holds the exposure configuration stable while a frame is running. It sits between the host register bank (shadow configuration, START/STOP) and the exposure sequencer, and both share RESET and CLK_HS.

## Interface
- C_TIMEOUT, 100000000: watchdog limit, in CLK_HS cycles, per state visit.
- C_EXP_DEF, 10: reset value of exposure per subscene, in 100×CLK_HS units.
- C_NPAT_DEF, 100: reset value of patterns per frame.
- C_NMC_DEF, 0: reset value of mask changes per frame.
- C_MCS_DEF, 1: reset value of subscenes per mask change.

- CLK_HS  in  1  system clock.
- RESET  in  1  synchronous, active-high.
- START  in  1  one-cycle pulse that starts a run.
- STOP  in  1  one-cycle pulse that ends a run after the current frame.
- MODE  in  1  run mode: 0 = counted run, 1 = continuous.
- NUM_FRAMES  in  32  frame count for a counted run.
- CFG_WE  in  1  write strobe; captures all four CFG_* inputs into shadow registers.
- CFG_EXP, CFG_NPAT, CFG_NMC, CFG_MCS  in  32 each  shadow configuration inputs.
- Exp_subc, Num_Pat, Num_Mask_change, Mask_change_subc  out  32 each  active configuration presented to the exposure sequencer.
- FSMIND1  in  1  exposure frame finished; asserted by the sequencer.
- FSMIND1ACK  out  1  acknowledges FSMIND1.
- FSMIND0  out  1  request that the sequencer start the next frame.
- FSMIND0ACK  in  1  sequencer accepted FSMIND0; stays high until the frame ends.
- RO_START  out  1  one-cycle pulse that starts ADC readout.
- RO_DONE  in  1  readout finished; one-cycle pulse.
- BUSY  out  1  high in every state except IDLE.
- FRAME_CNT  out  32  frames read out since the last START.
- TIMEOUT_ERR  out  1  sticky watchdog error.
- sched_stat  out  3  current state code.

## Operation
- States and sched_stat codes: FLUSH=0, IDLE=1, RELEASE=2, EXPOSE=3, READOUT=4, ERROR=7.
- Reset values:
  - State is FLUSH.
  - FSMIND0, FSMIND1ACK, RO_START, TIMEOUT_ERR and FRAME_CNT are 0; BUSY is 1.
  - Active and shadow configuration both equal the C_*_DEF values.
- FLUSH: the sequencer runs one autonomous frame after reset, and that frame is discarded.
  - On FSMIND1=1: FSMIND1ACK←1, then go to IDLE. No RO_START is issued.
- IDLE: the sequencer is parked waiting for FSMIND0; FSMIND1ACK stays 1.
  - START is ignored if STOP is high in the same cycle (STOP wins).
  - START is ignored if MODE=0 and NUM_FRAMES=0.
  - Otherwise START latches MODE and NUM_FRAMES, clears FRAME_CNT and the pending-stop flag, and goes to RELEASE.
- RELEASE:
  - On entry: copy shadow configuration to the active outputs and set FSMIND0←1.
  - On FSMIND0ACK=1: FSMIND0←0, FSMIND1ACK←0, go to EXPOSE.
- EXPOSE: on FSMIND1=1, set FSMIND1ACK←1, pulse RO_START for one cycle, and go to READOUT.
- READOUT: on RO_DONE, FRAME_CNT←FRAME_CNT+1, then:
  - go to IDLE if the pending-stop flag is set, or if MODE=0 and the new FRAME_CNT equals NUM_FRAMES;
  - otherwise go to RELEASE.
- STOP received in any state other than IDLE sets the pending-stop flag. The current frame still completes and is read out.
- START received while BUSY=1 is ignored.
- Configuration writes:
  - CFG_WE is accepted in any state but affects only the shadow registers.
  - The active outputs change only on entry to RELEASE, when the sequencer is parked.
  - A written CFG_EXP or CFG_MCS of 0 is stored as 1.
- ERROR: FSMIND0, FSMIND1ACK and RO_START are forced to 0 and TIMEOUT_ERR=1. Only RESET exits this state.
- FRAME_CNT wraps modulo 2^32 in continuous mode.

## Timing
- All outputs are registered; no combinational paths from inputs to outputs.
- FSMIND1 sampled high at edge n → FSMIND1ACK=1 and RO_START=1 after edge n+1; RO_START=0 after edge n+2.
- RO_DONE sampled at edge m → FRAME_CNT updated after edge m+1. On the same edge, the active configuration updates and FSMIND0=1 (when the next state is RELEASE).
- FSMIND0ACK sampled at edge k → FSMIND0=0 and FSMIND1ACK=0 after edge k+1.
- RO_DONE seen outside READOUT, and FSMIND1 seen outside FLUSH and EXPOSE, are ignored.
- RESET mid-frame: the next edge applies all reset values. The sequencer resets on the same edge, so FLUSH matches its autonomous frame.

## Configuration
- SCHED_WATCHDOG_EN defined:
  - A 32-bit counter clears on every state entry and increments in FLUSH, RELEASE, EXPOSE and READOUT.
  - When it reaches C_TIMEOUT, the next state is ERROR.
- SCHED_WATCHDOG_EN undefined: no counter is built, ERROR is unreachable, and TIMEOUT_ERR is tied to 0.

## Test plan
- Reset, sequencer model raises FSMIND1 after 50 cycles → FSMIND1ACK=1 one cycle later, no RO_START, sched_stat=1, BUSY=0.
- MODE=0, NUM_FRAMES=3, START → exactly 3 RO_START pulses and 3 FSMIND0 handshakes, FRAME_CNT=3, then IDLE with FSMIND0=0.
- MODE=1, START, STOP during the 2nd EXPOSE → the 2nd frame is read out, FRAME_CNT=2, IDLE, no 3rd FSMIND0.
- CFG_WE with CFG_EXP=25 during EXPOSE → Exp_subc stays 10 until the next RELEASE entry, then becomes 25. CFG_MCS=0 → Mask_change_subc=1.
- START with STOP in the same cycle, and START with MODE=0 and NUM_FRAMES=0 → both ignored, stays IDLE, FRAME_CNT unchanged.
- With SCHED_WATCHDOG_EN defined, C_TIMEOUT=1000, withhold RO_DONE → ERROR after 1000 cycles in READOUT, TIMEOUT_ERR=1, handshakes 0, cleared only by RESET.
